// File: rtl/sal_bus_if_slice.sv
// sal_bus_if_slice: registers one AXI address channel (upstream -> downstream) and one
// AXI write-response channel (downstream -> upstream) through 2-entry skid buffers,
// with a small APB slave for enable control, occupancy status and handshake counters.
// Optional feature: define BUS_IF_ACHK_EN to flag non-INCR or len > 15 address bursts
// in the sticky STATUS.ERR bit.
module sal_bus_if_slice #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [11:0]           paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic                  s_a_valid,
    output logic                  s_a_ready,
    input  logic [ID_WIDTH-1:0]   s_a_id,
    input  logic [ADDR_WIDTH-1:0] s_a_addr,
    input  logic [7:0]            s_a_len,
    input  logic [2:0]            s_a_size,
    input  logic [1:0]            s_a_burst,
    output logic                  m_a_valid,
    input  logic                  m_a_ready,
    output logic [ID_WIDTH-1:0]   m_a_id,
    output logic [ADDR_WIDTH-1:0] m_a_addr,
    output logic [7:0]            m_a_len,
    output logic [2:0]            m_a_size,
    output logic [1:0]            m_a_burst,
    input  logic                  m_b_valid,
    output logic                  m_b_ready,
    input  logic [ID_WIDTH-1:0]   m_b_id,
    input  logic [1:0]            m_b_resp,
    output logic                  s_b_valid,
    input  logic                  s_b_ready,
    output logic [ID_WIDTH-1:0]   s_b_id,
    output logic [1:0]            s_b_resp
);

    localparam int AP_W = ID_WIDTH + ADDR_WIDTH + 13;
    localparam int BP_W = ID_WIDTH + 2;

    // rdy_q holds both input readies low until the first clock after reset release
    logic            rdy_q;
    logic            en_q, en_d;
    logic            a_main_vld_q, a_main_vld_d, a_skid_vld_q, a_skid_vld_d;
    logic [AP_W-1:0] a_main_q, a_main_d, a_skid_q, a_skid_d, a_in;
    logic            b_main_vld_q, b_main_vld_d, b_skid_vld_q, b_skid_vld_d;
    logic [BP_W-1:0] b_main_q, b_main_d, b_skid_q, b_skid_d, b_in;
    logic [31:0]     a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic            a_in_hs, a_out_hs, b_in_hs, b_out_hs;
    logic            apb_wr, addr_ok, err_w;
    logic [1:0]      a_occ, b_occ;
    logic            unused_ok;

    assign a_in = {s_a_id, s_a_addr, s_a_len, s_a_size, s_a_burst};
    assign b_in = {m_b_id, m_b_resp};
    assign {m_a_id, m_a_addr, m_a_len, m_a_size, m_a_burst} = a_main_q;
    assign {s_b_id, s_b_resp} = b_main_q;

    assign s_a_ready = rdy_q & ~a_skid_vld_q & en_q;
    assign m_b_ready = rdy_q & ~b_skid_vld_q;
    assign m_a_valid = a_main_vld_q;
    assign s_b_valid = b_main_vld_q;

    assign a_in_hs  = s_a_valid & s_a_ready;
    assign a_out_hs = a_main_vld_q & m_a_ready;
    assign b_in_hs  = m_b_valid & m_b_ready;
    assign b_out_hs = b_main_vld_q & s_b_ready;

    assign a_occ = {1'b0, a_main_vld_q} + {1'b0, a_skid_vld_q};
    assign b_occ = {1'b0, b_main_vld_q} + {1'b0, b_skid_vld_q};

    assign apb_wr    = psel & penable & pwrite;
    assign addr_ok   = (paddr[11:4] == 8'h00);
    assign pready    = 1'b1;
    assign pslverr   = psel & penable & ~addr_ok;
    assign unused_ok = &{1'b0, paddr[1:0], pwdata};

    // A channel: main refills from skid first, then from the input; stalled input goes to skid
    always_comb begin
        a_main_vld_d = a_main_vld_q;
        a_main_d     = a_main_q;
        a_skid_vld_d = a_skid_vld_q;
        a_skid_d     = a_skid_q;
        if (a_out_hs || !a_main_vld_q) begin
            if (a_skid_vld_q) begin
                a_main_vld_d = 1'b1;
                a_main_d     = a_skid_q;
                a_skid_vld_d = 1'b0;
            end else if (a_in_hs) begin
                a_main_vld_d = 1'b1;
                a_main_d     = a_in;
            end else begin
                a_main_vld_d = 1'b0;
            end
        end else if (a_in_hs) begin
            a_skid_vld_d = 1'b1;
            a_skid_d     = a_in;
        end
    end

    // B channel: same skid discipline as the A channel, without the enable gate
    always_comb begin
        b_main_vld_d = b_main_vld_q;
        b_main_d     = b_main_q;
        b_skid_vld_d = b_skid_vld_q;
        b_skid_d     = b_skid_q;
        if (b_out_hs || !b_main_vld_q) begin
            if (b_skid_vld_q) begin
                b_main_vld_d = 1'b1;
                b_main_d     = b_skid_q;
                b_skid_vld_d = 1'b0;
            end else if (b_in_hs) begin
                b_main_vld_d = 1'b1;
                b_main_d     = b_in;
            end else begin
                b_main_vld_d = 1'b0;
            end
        end else if (b_in_hs) begin
            b_skid_vld_d = 1'b1;
            b_skid_d     = b_in;
        end
    end

    // Control register and counters; a counter clear overrides a same-cycle increment
    always_comb begin
        en_d    = en_q;
        a_cnt_d = a_cnt_q + {31'd0, a_in_hs};
        b_cnt_d = b_cnt_q + {31'd0, b_out_hs};
        if (apb_wr && addr_ok) begin
            case (paddr[3:2])
                2'd0:    en_d    = pwdata[0];
                2'd2:    a_cnt_d = 32'd0;
                2'd3:    b_cnt_d = 32'd0;
                default: ;
            endcase
        end
    end

`ifdef BUS_IF_ACHK_EN
    logic err_q, err_d;

    // Sticky burst check; a new offending transfer wins over a same-cycle clear
    always_comb begin
        err_d = err_q;
        if (apb_wr && addr_ok && (paddr[3:2] == 2'd1) && pwdata[4])
            err_d = 1'b0;
        if (a_in_hs && ((s_a_burst != 2'b01) || (s_a_len > 8'd15)))
            err_d = 1'b1;
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_w = err_q;
`else
    assign err_w = 1'b0;
`endif

    // APB read mux, combinational during any read access
    always_comb begin
        prdata = 32'd0;
        if (psel && !pwrite && addr_ok) begin
            case (paddr[3:2])
                2'd0:    prdata = {31'd0, en_q};
                2'd1:    prdata = {27'd0, err_w, b_occ, a_occ};
                2'd2:    prdata = a_cnt_q;
                default: prdata = b_cnt_q;
            endcase
        end
    end

    // State registers; reset discards every buffered entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q        <= 1'b0;
            en_q         <= 1'b1;
            a_main_vld_q <= 1'b0;
            a_skid_vld_q <= 1'b0;
            a_main_q     <= '0;
            a_skid_q     <= '0;
            b_main_vld_q <= 1'b0;
            b_skid_vld_q <= 1'b0;
            b_main_q     <= '0;
            b_skid_q     <= '0;
            a_cnt_q      <= 32'd0;
            b_cnt_q      <= 32'd0;
        end else begin
            rdy_q        <= 1'b1;
            en_q         <= en_d;
            a_main_vld_q <= a_main_vld_d;
            a_skid_vld_q <= a_skid_vld_d;
            a_main_q     <= a_main_d;
            a_skid_q     <= a_skid_d;
            b_main_vld_q <= b_main_vld_d;
            b_skid_vld_q <= b_skid_vld_d;
            b_main_q     <= b_main_d;
            b_skid_q     <= b_skid_d;
            a_cnt_q      <= a_cnt_d;
            b_cnt_q      <= b_cnt_d;
        end
    end

endmodule

// File: tb/tb_sal_bus_if_slice.sv
// Testbench for sal_bus_if_slice: directed scenarios plus a randomized phase, all
// compared against a queue-based reference model of the two channels and the APB map.
module tb_sal_bus_if_slice;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic        s_a_valid, s_a_ready, m_a_valid, m_a_ready;
    logic [3:0]  s_a_id, m_a_id;
    logic [31:0] s_a_addr, m_a_addr;
    logic [7:0]  s_a_len, m_a_len;
    logic [2:0]  s_a_size, m_a_size;
    logic [1:0]  s_a_burst, m_a_burst;
    logic        m_b_valid, m_b_ready, s_b_valid, s_b_ready;
    logic [3:0]  m_b_id, s_b_id;
    logic [1:0]  m_b_resp, s_b_resp;

    always #5 clk = ~clk;

    sal_bus_if_slice #(.ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_id(s_a_id),
        .s_a_addr(s_a_addr), .s_a_len(s_a_len), .s_a_size(s_a_size), .s_a_burst(s_a_burst),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_id(m_a_id),
        .m_a_addr(m_a_addr), .m_a_len(m_a_len), .m_a_size(m_a_size), .m_a_burst(m_a_burst),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp)
    );

    // Reference model: each channel is a FIFO of capacity 2
    logic [48:0] qa[$];
    logic [5:0]  qb[$];
    logic        en_m, err_m, rdy_m;
    logic [31:0] acnt_m, bcnt_m;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;
    logic        last_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        en_m   = 1'b1;
        err_m  = 1'b0;
        rdy_m  = 1'b0;
        acnt_m = 32'd0;
        bcnt_m = 32'd0;
    endtask

    function automatic logic [31:0] model_rd(input logic [11:0] a);
        logic [1:0] ao, bo;
        ao = 2'(qa.size());
        bo = 2'(qb.size());
        if (a[11:4] != 8'h00) return 32'd0;
        case (a[3:2])
            2'd0:    return {31'd0, en_m};
            2'd1:    return {27'd0, err_m, bo, ao};
            2'd2:    return acnt_m;
            default: return bcnt_m;
        endcase
    endfunction

    // One clock cycle: check outputs mid-cycle, then advance the model on the edge
    task automatic cyc();
        logic a_rdy, b_rdy, a_hs, a_out, b_in, b_out, wr;
        #1;
        a_rdy = rdy_m && en_m && (qa.size() < 2);
        b_rdy = rdy_m && (qb.size() < 2);
        chk("s_a_ready", 64'(s_a_ready), 64'(a_rdy));
        chk("m_a_valid", 64'(m_a_valid), 64'(qa.size() > 0));
        if (qa.size() > 0)
            chk("m_a_payload", 64'({m_a_id, m_a_addr, m_a_len, m_a_size, m_a_burst}), 64'(qa[0]));
        chk("m_b_ready", 64'(m_b_ready), 64'(b_rdy));
        chk("s_b_valid", 64'(s_b_valid), 64'(qb.size() > 0));
        if (qb.size() > 0)
            chk("s_b_payload", 64'({s_b_id, s_b_resp}), 64'(qb[0]));
        chk("pready", 64'(pready), 64'd1);
        chk("pslverr", 64'(pslverr), 64'(psel && penable && (paddr[11:4] != 8'h00)));
        chk("prdata", 64'(prdata), (psel && !pwrite) ? 64'(model_rd(paddr)) : 64'd0);
        last_rd  = prdata;
        last_err = pslverr;
        @(posedge clk);
        if (rst_n) begin
            a_hs  = s_a_valid && a_rdy;
            a_out = (qa.size() > 0) && m_a_ready;
            b_in  = m_b_valid && b_rdy;
            b_out = (qb.size() > 0) && s_b_ready;
            wr    = psel && penable && pwrite && (paddr[11:4] == 8'h00);
            if (a_out) void'(qa.pop_front());
            if (a_hs)  qa.push_back({s_a_id, s_a_addr, s_a_len, s_a_size, s_a_burst});
            if (b_out) void'(qb.pop_front());
            if (b_in)  qb.push_back({m_b_id, m_b_resp});
            if (a_hs)  acnt_m = acnt_m + 32'd1;
            if (b_out) bcnt_m = bcnt_m + 32'd1;
            if (wr) begin
                case (paddr[3:2])
                    2'd0: en_m = pwdata[0];
`ifdef BUS_IF_ACHK_EN
                    2'd1: if (pwdata[4]) err_m = 1'b0;
`endif
                    2'd2: acnt_m = 32'd0;
                    2'd3: bcnt_m = 32'd0;
                    default: ;
                endcase
            end
`ifdef BUS_IF_ACHK_EN
            if (a_hs && ((s_a_burst != 2'b01) || (s_a_len > 8'd15))) err_m = 1'b1;
`endif
            rdy_m = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        cyc();
        penable = 1'b1;
        cyc();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] rd, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        cyc();
        penable = 1'b1;
        cyc();
        rd  = last_rd;
        err = last_err;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic set_a(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        s_a_id = id; s_a_addr = addr; s_a_len = len; s_a_size = size; s_a_burst = burst;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 12'h0; pwdata = 32'h0;
        s_a_valid = 1'b0; set_a(4'h0, 32'h0, 8'h0, 3'h0, 2'h0);
        m_a_ready = 1'b0; m_b_valid = 1'b0; m_b_id = 4'h0; m_b_resp = 2'h0; s_b_ready = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_m_a_valid", 64'(m_a_valid), 64'd0);
        chk("rst_s_b_valid", 64'(s_b_valid), 64'd0);
        chk("rst_s_a_ready", 64'(s_a_ready), 64'd0);
        chk("rst_m_b_ready", 64'(m_b_ready), 64'd0);
        chk("rst_m_a_payload", 64'({m_a_id, m_a_addr, m_a_len, m_a_size, m_a_burst}), 64'd0);
        chk("rst_s_b_payload", 64'({s_b_id, s_b_resp}), 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        #1;
        chk("ready_after_release", 64'(s_a_ready), 64'd1);
        apb_read(12'h000, rd, e);
        chk("ctrl_reset", 64'(rd), 64'd1);
        apb_read(12'h008, rd, e);
        chk("a_cnt_reset", 64'(rd), 64'd0);

        // Single A transfer, one cycle latency
        m_a_ready = 1'b1; s_b_ready = 1'b1;
        set_a(4'h0, 32'h0, 8'd1, 3'b100, 2'b01);
        s_a_valid = 1'b1;
        cyc();
        s_a_valid = 1'b0;
        #1;
        chk("first_m_a_valid", 64'(m_a_valid), 64'd1);
        chk("first_m_a_len", 64'(m_a_len), 64'd1);
        chk("first_m_a_size", 64'(m_a_size), 64'd4);
        chk("first_m_a_burst", 64'(m_a_burst), 64'd1);
        cyc();
        apb_read(12'h008, rd, e);
        chk("a_cnt_one", 64'(rd), 64'd1);

        // Fill both entries under back-pressure, then drain in order
        m_a_ready = 1'b0;
        set_a(4'h1, 32'h0, 8'd2, 3'b010, 2'b01);
        s_a_valid = 1'b1;
        cyc();
        set_a(4'h2, 32'h20, 8'd3, 3'b010, 2'b01);
        cyc();
        s_a_valid = 1'b0;
        apb_read(12'h004, rd, e);
        chk("status_a_full", 64'(rd & 32'h3), 64'd2);
        chk("full_s_a_ready", 64'(s_a_ready), 64'd0);
        m_a_ready = 1'b1;
        #1;
        chk("drain_first_addr", 64'(m_a_addr), 64'h0);
        cyc();
        #1;
        chk("drain_second_addr", 64'(m_a_addr), 64'h20);
        cyc();
        apb_read(12'h004, rd, e);
        chk("status_a_empty", 64'(rd & 32'h3), 64'd0);

        // B response under a stalling upstream
        s_b_ready = 1'b0;
        m_b_valid = 1'b1; m_b_id = 4'h0; m_b_resp = 2'b00;
        cyc();
        m_b_valid = 1'b0;
        cyc();
        #1;
        chk("b_stalled_valid", 64'(s_b_valid), 64'd1);
        chk("b_stalled_payload", 64'({s_b_id, s_b_resp}), 64'd0);
        s_b_ready = 1'b1;
        cyc();
        s_b_ready = 1'b0;
        cyc();
        apb_read(12'h00C, rd, e);
        chk("b_cnt_one", 64'(rd), 64'd1);

        // Enable gating of the A input
        apb_write(12'h000, 32'h0);
        set_a(4'h3, 32'h100, 8'd0, 3'b011, 2'b01);
        s_a_valid = 1'b1;
        cyc();
        cyc();
        #1;
        chk("disabled_s_a_ready", 64'(s_a_ready), 64'd0);
        apb_write(12'h000, 32'h1);
        #1;
        chk("reenabled_s_a_ready", 64'(s_a_ready), 64'd1);
        cyc();
        s_a_valid = 1'b0;
        cyc();
        cyc();

        // Unmapped address and clear-over-increment
        apb_read(12'h010, rd, e);
        chk("bad_addr_prdata", 64'(rd), 64'd0);
        chk("bad_addr_pslverr", 64'(e), 64'd1);
        apb_write(12'h010, 32'hFFFF_FFFF);
        set_a(4'h4, 32'h200, 8'd1, 3'b010, 2'b01);
        s_a_valid = 1'b1;
        apb_write(12'h008, 32'h0);
        s_a_valid = 1'b0;
        apb_read(12'h008, rd, e);
        chk("a_cnt_clear_wins", 64'(rd), 64'd0);
        cyc();
        cyc();

        // Burst check
        set_a(4'h5, 32'h40, 8'd3, 3'b010, 2'b10);
        s_a_valid = 1'b1;
        cyc();
        s_a_valid = 1'b0;
        #1;
        chk("bad_burst_forwarded", 64'(m_a_burst), 64'd2);
        cyc();
        apb_read(12'h004, rd, e);
`ifdef BUS_IF_ACHK_EN
        chk("err_set_burst", 64'((rd >> 4) & 32'h1), 64'd1);
        apb_write(12'h004, 32'h10);
        apb_read(12'h004, rd, e);
        chk("err_cleared", 64'((rd >> 4) & 32'h1), 64'd0);
        set_a(4'h6, 32'h80, 8'd16, 3'b010, 2'b01);
        s_a_valid = 1'b1;
        cyc();
        s_a_valid = 1'b0;
        cyc();
        apb_read(12'h004, rd, e);
        chk("err_set_len", 64'((rd >> 4) & 32'h1), 64'd1);
        apb_write(12'h004, 32'h10);
`else
        chk("err_absent", 64'((rd >> 4) & 32'h1), 64'd0);
`endif

        // Randomized traffic on both channels
        for (int i = 0; i < 400; i++) begin
            s_a_valid = 1'($urandom_range(0, 1));
            set_a(4'($urandom), $urandom, 8'($urandom_range(0, 31)), 3'($urandom), 2'($urandom));
            m_a_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            m_b_valid = 1'($urandom_range(0, 1));
            m_b_id    = 4'($urandom);
            m_b_resp  = 2'($urandom);
            s_b_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (i == 100)         apb_write(12'h000, 32'h0);
            else if (i == 130)    apb_write(12'h000, 32'h1);
            else if (i % 40 == 39) apb_read(12'h004, rd, e);
            else if (i % 40 == 19) apb_read(12'h008, rd, e);
            else                  cyc();
        end
        s_a_valid = 1'b0; m_b_valid = 1'b0; m_a_ready = 1'b1; s_b_ready = 1'b1;
        cyc(); cyc(); cyc();
        apb_read(12'h004, rd, e);
        chk("drained_occupancy", 64'(rd & 32'hF), 64'd0);

        // Asynchronous reset with both channels full
        m_a_ready = 1'b0; s_b_ready = 1'b0; s_a_valid = 1'b1; m_b_valid = 1'b1;
        cyc(); cyc(); cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_a_valid", 64'(m_a_valid), 64'd0);
        chk("midrst_s_b_valid", 64'(s_b_valid), 64'd0);
        chk("midrst_s_a_ready", 64'(s_a_ready), 64'd0);
        chk("midrst_m_a_addr", 64'(m_a_addr), 64'd0);
        model_reset();
        s_a_valid = 1'b0; m_b_valid = 1'b0;
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        m_a_ready = 1'b1; s_b_ready = 1'b1;
        cyc();
        apb_read(12'h004, rd, e);
        chk("post_rst_status", 64'(rd), 64'd0);
        apb_read(12'h00C, rd, e);
        chk("post_rst_b_cnt", 64'(rd), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
